ipml_fifo_burst_reader: RTL and testbench

Read-side consumer for the prefetch FIFO's first-word-fall-through read port (rd_data/rd_vld/rd_en, where a pop occurs when rd_vld and rd_en are both high).
Accepts a burst command, pops exactly the commanded number of words, and re-presents them on a registered valid/ready stream with a last-beat marker.
Sits between the audio sample FIFO and downstream DSP/DMA logic, in the rd_clk domain.

---
 rtl/ipml_fifo_burst_reader_pkg.sv | 28 ++
 rtl/ipml_fifo_rd_outreg.sv | 53 +++++
 rtl/ipml_fifo_burst_reader.sv | 151 +++++++++++++++
 tb/tb_ipml_fifo_burst_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipml_fifo_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ipml_fifo_burst_reader_pkg
// Description : Shared types and sizing helpers for the FIFO burst reader
//               and its output register.
// Revision    : 1.0  initial release
// ============================================================================
package ipml_fifo_burst_reader_pkg;

    // Burst reader control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Default burst length field width and the matching beat counter width.
    // The counter carries one extra bit so a full 2^LEN_W beat burst never wraps.
    localparam int C_LEN_W_DEFAULT = 8;
    localparam int C_CNT_W_DEFAULT = C_LEN_W_DEFAULT + 1;

    // Beat counter width for a given length field width
    function automatic int cnt_width(input int len_w);
        return len_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ipml_fifo_rd_outreg.sv
`default_nettype none
// ============================================================================
// Module      : ipml_fifo_rd_outreg
// Description : Output data/valid/last register for read-side FIFO consumers.
//               Loads a beat on load_i, holds it while the sink stalls, and
//               drops valid once the beat is taken with nothing new behind it.
// Revision    : 1.0  initial release
// ============================================================================
module ipml_fifo_rd_outreg #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              force_last_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              last_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              last_q;

    // Beat register: load new word, otherwise hold data/last until accepted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
            last_q  <= last_i;
        end else begin
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
            if (force_last_i) begin
                last_q <= 1'b1;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule
`default_nettype wire

// File: rtl/ipml_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : ipml_fifo_burst_reader
// Description : Pops a commanded burst (cmd_len+1 words) from a first-word-
//               fall-through FIFO read port and re-presents it as a registered
//               valid/ready stream with a last-beat marker.
//               Optional macro FIFO_RD_TIMEOUT_EN adds a starvation timeout
//               that aborts a stalled burst and pulses err.
// Revision    : 1.0  initial release
// ============================================================================
import ipml_fifo_burst_reader_pkg::*;

module ipml_fifo_burst_reader #(
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_vld,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = cnt_width(LEN_W);

    rd_state_e        state_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             err_q;

    logic             w_pop;
    logic             w_last_beat;
    logic             w_abort;
    logic             w_force_last;

    // Pop only when the output register can take the word; never looks at fifo_rd_vld
    assign fifo_rd_en   = (state_q == ST_RUN) && (!m_valid || m_ready);
    assign w_pop        = fifo_rd_en && fifo_rd_vld;
    assign w_last_beat  = (cnt_q == {1'b0, len_q});
    assign w_force_last = w_abort && m_valid && !m_ready;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int              STV_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [STV_W-1:0] C_STV_MAX = STV_W'(TIMEOUT_CYC - 1);

    logic [STV_W-1:0] starv_q;

    // Count cycles spent asking for data the FIFO cannot supply
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            starv_q <= '0;
        end else if ((state_q != ST_RUN) || w_pop) begin
            starv_q <= '0;
        end else if (fifo_rd_en && !fifo_rd_vld && (starv_q != C_STV_MAX)) begin
            starv_q <= starv_q + STV_W'(1);
        end
    end

    assign w_abort = (state_q == ST_RUN) && (starv_q == C_STV_MAX) && !w_pop;
`else
    // Without the timeout the burst waits for data indefinitely
    if (TIMEOUT_CYC > 0) begin : g_no_timeout
        assign w_abort = 1'b0;
    end else begin : g_no_timeout_zero
        assign w_abort = 1'b0;
    end
`endif

    // Burst control FSM with registered done/err pulses
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        len_q   <= cmd_len;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_pop) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (w_last_beat) begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (w_abort) begin
                        err_q <= 1'b1;
                        if (m_valid && !m_ready) begin
                            // A beat is still stalled: close the burst on it
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_valid && m_ready && m_last) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    ipml_fifo_rd_outreg #(
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk_i        (rd_clk),
        .rst_i        (rd_rst),
        .load_i       (w_pop),
        .data_i       (fifo_rd_data),
        .last_i       (w_last_beat),
        .force_last_i (w_force_last),
        .ready_i      (m_ready),
        .data_o       (m_data),
        .valid_o      (m_valid),
        .last_o       (m_last)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ipml_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipml_fifo_burst_reader
// Description : Self-checking bench for ipml_fifo_burst_reader. A simple
//               array FIFO feeds the DUT; expected beats come from the order
//               words were pushed, burst lengths and pop/beat totals.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ipml_fifo_burst_reader;

    localparam int DATA_W      = 32;
    localparam int LEN_W       = 4;
    localparam int TIMEOUT_CYC = 16;

    logic              rd_clk = 1'b0;
    logic              rd_rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_vld;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic              m_last;
    logic              busy;
    logic              done;
    logic              err;

    ipml_fifo_burst_reader #(
        .DATA_W      (DATA_W),
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_en   (fifo_rd_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 rd_clk = ~rd_clk;

    // Reference FIFO: words in push order, read pointer advances on each pop
    logic [DATA_W-1:0] mem [0:1023];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic starve = 1'b0;

    assign fifo_rd_vld  = (rd_ptr != wr_ptr) && !starve;
    assign fifo_rd_data = mem[rd_ptr[9:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, pops = 0, last_pop_cyc = 0;
    int beats = 0, beat_cnt = 0, exp_idx = 0, cur_len = 0;
    int first_beat_cyc = 0, last_beat_cyc = 0, done_cyc = 0;
    logic              prev_stall = 1'b0;
    logic              prev_last  = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // FIFO side: pop on fifo_rd_en & fifo_rd_vld
    always @(posedge rd_clk) begin
        cyc <= cyc + 1;
        if (!rd_rst && fifo_rd_en && fifo_rd_vld) begin
            rd_ptr       <= rd_ptr + 1;
            pops         <= pops + 1;
            last_pop_cyc <= cyc + 1;
        end
    end

    // Stream monitor: every accepted beat must be the next FIFO word in order
    always @(negedge rd_clk) begin
        if (rd_rst) begin
            exp_idx    = rd_ptr;
            beat_cnt   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", {31'd0, m_valid}, 32'd1);
                check_eq("hold_data", m_data, prev_data);
                check_eq("hold_last", {31'd0, m_last}, {31'd0, prev_last});
            end
            if (fifo_rd_en && cmd_ready)
                check_eq("pop_in_idle", {31'd0, fifo_rd_en}, 32'd0);
`ifndef FIFO_RD_TIMEOUT_EN
            if (err)
                check_eq("err_default", {31'd0, err}, 32'd0);
`endif
            if (m_valid && m_ready) begin
                check_eq("beat_data", m_data, mem[exp_idx[9:0]]);
                check_eq("beat_last", {31'd0, m_last}, {31'd0, (beat_cnt == cur_len)});
                exp_idx++;
                beat_cnt++;
                beats++;
                last_beat_cyc = cyc;
                if (beat_cnt == 1) first_beat_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[9:0]] = $urandom;
            wr_ptr++;
        end
    endtask

    task automatic issue_cmd(input int len);
        int t = 0;
        while (!cmd_ready && t < 100) begin
            @(posedge rd_clk); #1;
            t++;
        end
        check_eq("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        cur_len   = len;
        beat_cnt  = 0;
        @(posedge rd_clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Run until done, with random (or 1,0,0 patterned) ready and FIFO starvation
    task automatic finish_burst(input int len, input int p0, input int b0,
                                input int rdy_pct, input int stv_pct, input bit pat);
        int  t = 0;
        bit  seen = 0;
        while (!seen && t < 600) begin
            if (pat) m_ready = (t % 3 == 0);
            else     m_ready = ($urandom_range(99) < rdy_pct);
            starve = ($urandom_range(99) < stv_pct);
            @(posedge rd_clk); #1;
            t++;
            if (done) seen = 1;
        end
        done_cyc = cyc;
        check_eq("done_seen", {31'd0, seen}, 32'd1);
        check_eq("pop_total", pops - p0, len + 1);
        check_eq("beat_total", beats - b0, len + 1);
        check_eq("cmd_ready_at_done", {31'd0, cmd_ready}, 32'd1);
        check_eq("busy_at_done", {31'd0, busy}, 32'd0);
        m_ready = 1'b1;
        starve  = 1'b0;
    endtask

    task automatic run_burst(input int len, input int rdy_pct, input int stv_pct, input bit pat);
        int p0, b0;
        push_words(len + 1);
        p0 = pops;
        b0 = beats;
        issue_cmd(len);
        finish_burst(len, p0, b0, rdy_pct, stv_pct, pat);
    endtask

    initial begin
        int p0, b0, t, len;
        // Reset state
        repeat (3) @(posedge rd_clk);
        #1;
        check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check_eq("rst_m_last", {31'd0, m_last}, 32'd0);
        check_eq("rst_m_data", m_data, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rd_rst = 1'b0;
        @(posedge rd_clk); #1;

        // Continuous data: words 0..7 preloaded, 4-beat burst
        for (int i = 0; i < 8; i++) begin
            mem[i] = i;
        end
        wr_ptr = 8;
        p0 = pops; b0 = beats;
        issue_cmd(3);
        finish_burst(3, p0, b0, 100, 0, 1'b0);
        check_eq("cont_span", last_beat_cyc - first_beat_cyc, 3);
        check_eq("cont_done_lag", done_cyc - last_beat_cyc, 1);

        // Backpressure 1,0,0 pattern, 3 beats
        run_burst(2, 0, 0, 1'b1);

        // Starved FIFO mid-burst, 5 beats
        push_words(5);
        p0 = pops; b0 = beats;
        issue_cmd(4);
        @(posedge rd_clk); #1;
        starve = 1'b1;
        @(posedge rd_clk); #1;
        t = pops;
        repeat (5) begin
            @(posedge rd_clk); #1;
        end
        check_eq("starve_no_pop", pops - t, 0);
        finish_burst(4, p0, b0, 100, 0, 1'b0);
        check_eq("starve_err", {31'd0, err}, 32'd0);

        // Full-range length: 16 beats
        run_burst(15, 100, 0, 1'b0);

        // Reset after two beats of an 8-beat burst
        push_words(8);
        b0 = beats;
        issue_cmd(7);
        t = 0;
        while ((beats - b0) < 2 && t < 100) begin
            @(posedge rd_clk); #1;
            t++;
        end
        check_eq("rst_mid_beats", {31'd0, ((beats - b0) >= 2)}, 32'd1);
        rd_rst = 1'b1;
        #1;
        check_eq("rstm_m_valid", {31'd0, m_valid}, 32'd0);
        check_eq("rstm_m_last", {31'd0, m_last}, 32'd0);
        check_eq("rstm_m_data", m_data, 32'd0);
        check_eq("rstm_busy", {31'd0, busy}, 32'd0);
        check_eq("rstm_fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        @(posedge rd_clk); #1;
        rd_rst = 1'b0;
        run_burst(3, 100, 0, 1'b0);

        // Randomized bursts
        for (int k = 0; k < 12; k++) begin
            len = $urandom_range(0, 15);
            run_burst(len, $urandom_range(40, 100), $urandom_range(0, 40), 1'b0);
        end

`ifdef FIFO_RD_TIMEOUT_EN
        // Timeout: only 2 of 6 words ever arrive
        push_words(2);
        p0 = pops; b0 = beats;
        issue_cmd(5);
        t = 0;
        while (!err && t < 200) begin
            @(posedge rd_clk); #1;
            t++;
        end
        check_eq("to_err_seen", {31'd0, err}, 32'd1);
        check_eq("to_err_delay", cyc - last_pop_cyc, TIMEOUT_CYC);
        check_eq("to_done", {31'd0, done}, 32'd1);
        check_eq("to_m_valid", {31'd0, m_valid}, 32'd0);
        check_eq("to_idle", {31'd0, cmd_ready}, 32'd1);
        check_eq("to_beats", beats - b0, 2);
        check_eq("to_pops", pops - p0, 2);
        @(posedge rd_clk); #1;
        check_eq("to_err_pulse", {31'd0, err}, 32'd0);
`endif

        repeat (3) @(posedge rd_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
